lcd_scanout: RTL and testbench
==============================

Name: lcd_scanout

Overview:
- Downstream consumer of the LCD controller's display-RAM read port (`read_x` / `read_y` / `read_column`).
- On each `frame_start` pulse it walks the visible 96x64 area and copies every column byte into a double-buffered shadow frame.
- The video side reads pixels at random from the shadow frame. Each pixel is returned as a 2-bit intensity that blends the current and previous frame, emulating LCD ghosting.
- The video side never touches the controller's RAM directly.

Parameters:
- `WIDTH`, 96, visible columns read per page (column addresses 0..WIDTH-1).
- `PAGES`, 8, pages read per frame (page 8, the 1-pixel icon row, is never read).
- `GHOSTING`, 1, 1 = blend current and previous frames; 0 = current frame only.

Ports:
- `clk`  in  1  system clock, single domain.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse requesting a frame capture.
- `read_x`  out  8  column address to the LCD controller.
- `read_y`  out  4  page address to the LCD controller.
- `read_column`  in  8  byte from the LCD controller; valid the cycle after `read_x`/`read_y` are presented. Bit n = row page*8+n.
- `busy`  out  1  high while a capture is in progress.
- `frame_done`  out  1  one-cycle pulse when a capture completes and the banks swap.
- `overrun`  out  1  one-cycle pulse when `frame_start` arrives while `busy`.
- `pix_x`  in  7  video pixel column, 0..95.
- `pix_y`  in  6  video pixel row, 0..63.
- `pix_level`  out  2  pixel intensity; 0 = off, 3 = fully on.

Behaviour:
- Reset state and values:
  - State IDLE.
  - `read_x`=0, `read_y`=0.
  - `busy`=0, `frame_done`=0, `overrun`=0.
  - `pix_level`=0.
  - `active_bank`=0, `valid`=0.
  - Shadow RAM contents are not cleared.
- Shadow storage: two banks of `WIDTH`*`PAGES` bytes (768 each).
  - Byte index = page*`WIDTH` + x.
  - Captures always write to bank `~active_bank`.
- State machine: IDLE -> CAPTURE -> DRAIN -> IDLE.
  - IDLE:
    - On `frame_start`: zero the x/page counters, go to CAPTURE, set `busy`=1.
  - CAPTURE:
    - Present one address per cycle: `read_x`=x, `read_y`=page.
    - x increments 0..`WIDTH`-1, then wraps to 0 and page increments.
    - After address (`WIDTH`-1, `PAGES`-1) is presented, go to DRAIN.
  - Write pipeline:
    - A one-stage pipeline carries the byte index and a valid bit.
    - The cycle after an address is presented, `read_column` is written to bank `~active_bank` at that index.
  - DRAIN (1 cycle):
    - Final byte is written.
    - Toggle `active_bank`, set `valid`=1, pulse `frame_done`, clear `busy`, return to IDLE.
  - Capture length: `frame_start` seen at edge N -> `frame_done` high in cycle N+1+768.
- `frame_start` while `busy`:
  - Ignored; the capture continues unchanged.
  - `overrun` pulses for one cycle.
  - `frame_start` in the same cycle as DRAIN counts as busy and is ignored.
- Reset mid-capture:
  - Abort immediately; no bank swap, no `frame_done`.
  - All values return to the reset state listed above, including `valid`=0.
- Video read path, fixed latency 2 cycles (`pix_x`/`pix_y` in cycle N -> `pix_level` in cycle N+2), fully pipelined, one request per cycle:
  - Stage 1:
    - Byte index = `pix_y`[5:3]*`WIDTH` + `pix_x`.
    - Read both banks.
    - Register bit select `pix_y`[2:0], an in-range flag, and `valid`.
  - Stage 2:
    - cur = bit from bank `active_bank`; prev = bit from the other bank.
    - With `GHOSTING`=1: `pix_level` = {cur, prev}, i.e. 3 both on, 2 cur only, 1 prev only, 0 none.
    - With `GHOSTING`=0: `pix_level` = cur ? 3 : 0.
    - Output 0 if out of range (`pix_x` >= 96) or `valid`=0.
- Bank swap relative to the read pipeline:
  - A read whose stage 1 coincides with the DRAIN cycle uses the pre-swap `active_bank`.
  - `active_bank` is sampled in stage 1 and carried to stage 2.
- Simultaneous capture write and video read on the same byte:
  - No conflict: the write bank is never the current bank.
  - The write bank is the prev bank, and prev data may update mid-frame while a capture runs.
- Arithmetic: index math is 10-bit unsigned. Page and x counters never exceed their limits.

Test Plan:
- LCD model returns byte = x ^ (page<<4); pulse `frame_start` -> `busy` high for 769 cycles, `frame_done` at N+769, exactly 768 distinct (x,page) addresses, last address (95,7).
- After one capture of all 0xFF -> `pix_level`(10,10)=2 (prev bank still unwritten/zero when LCD model starts from cleared RAM); second capture of 0xFF -> 3; third capture of 0x00 -> 1; fourth capture of 0x00 -> 0.
- `frame_start` at cycle 100 of a capture -> `overrun` pulse, `frame_done` timing unchanged, no second capture follows.
- Reset asserted at cycle 400 of the second capture -> `busy`=0, `pix_level`=0 everywhere, no `frame_done`; next full capture produces valid data.
- `pix_x`=96, `pix_y`=0 after valid frame -> `pix_level`=0; `pix_x`=95, `pix_y`=63 reads bit 7 of byte index 767 with 2-cycle latency.
- `GHOSTING`=0 build: alternating 0xFF/0x00 captures -> `pix_level` alternates 3/0, never 1 or 2.

Source files
------------

// File: rtl/lcd_scanout.sv
// Frame capture from the LCD controller's display RAM into a double-buffered
// shadow frame, with a 2-cycle random-access pixel read path that blends the
// current and previous frames to mimic LCD ghosting.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   frame_start             : one-cycle capture request
//   read_x, read_y          : column/page address to the LCD controller
//   read_column             : byte returned one cycle after the address
//   busy                    : capture in progress
//   frame_done              : pulse when a capture completes and banks swap
//   overrun                 : pulse when frame_start arrives while busy
//   pix_x, pix_y            : video pixel coordinate
//   pix_level               : 2-bit pixel intensity, 2 cycles after request
module lcd_scanout #(
  parameter int WIDTH    = 96,
  parameter int PAGES    = 8,
  parameter bit GHOSTING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  output logic [7:0] read_x,
  output logic [3:0] read_y,
  input  logic [7:0] read_column,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  input  logic [6:0] pix_x,
  input  logic [5:0] pix_y,
  output logic [1:0] pix_level
);

  localparam int DEPTH = WIDTH * PAGES;
  localparam logic [9:0] W10 = 10'(WIDTH);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [3:0] P_LAST = 4'(PAGES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t     state;
  logic       active_bank;
  logic       valid;
  logic [9:0] cap_idx;
  logic [9:0] wr_idx;
  logic       wr_vld;

  // Capture sequencer. cap_idx tracks page*WIDTH+x of the address
  // currently on read_x/read_y, so no multiply is needed on this side.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      read_x      <= '0;
      read_y      <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      active_bank <= 1'b0;
      valid       <= 1'b0;
      cap_idx     <= '0;
      wr_idx      <= '0;
      wr_vld      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      wr_vld     <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            read_x  <= '0;
            read_y  <= '0;
            cap_idx <= '0;
            busy    <= 1'b1;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          overrun <= frame_start;
          // Byte for the address now presented arrives next cycle.
          wr_vld  <= 1'b1;
          wr_idx  <= cap_idx;
          if (read_x == X_LAST) begin
            if (read_y == P_LAST) begin
              state <= DRAIN;
            end else begin
              read_x  <= '0;
              read_y  <= read_y + 4'd1;
              cap_idx <= cap_idx + 10'd1;
            end
          end else begin
            read_x  <= read_x + 8'd1;
            cap_idx <= cap_idx + 10'd1;
          end
        end
        DRAIN: begin
          overrun     <= frame_start;
          active_bank <= ~active_bank;
          valid       <= 1'b1;
          frame_done  <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0] bank0 [DEPTH];
  logic [7:0] bank1 [DEPTH];
  logic [7:0] rd0;
  logic [7:0] rd1;
  logic [9:0] rd_idx;
  logic       in_range;

  // Out-of-range requests are steered to index 0 so the array is never
  // addressed past its end; the registered flag masks the result.
  always_comb begin
    in_range = ({3'b000, pix_x} < W10);
    rd_idx   = '0;
    if (in_range) begin
      rd_idx = 10'(pix_y[5:3]) * W10 + 10'(pix_x);
    end
  end

  // Writes always target the non-active bank, which is sampled
  // before the DRAIN-edge toggle, so the last byte lands correctly.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      if (active_bank) begin
        bank0[wr_idx] <= read_column;
      end else begin
        bank1[wr_idx] <= read_column;
      end
    end
    rd0 <= bank0[rd_idx];
    rd1 <= bank1[rd_idx];
  end

  logic [2:0] s1_bit;
  logic       s1_rng;
  logic       s1_vld;
  logic       s1_bank;
  logic       cur;
  logic       prev;

  always_comb begin
    cur  = s1_bank ? rd1[s1_bit] : rd0[s1_bit];
    prev = s1_bank ? rd0[s1_bit] : rd1[s1_bit];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_bit    <= '0;
      s1_rng    <= 1'b0;
      s1_vld    <= 1'b0;
      s1_bank   <= 1'b0;
      pix_level <= '0;
    end else begin
      s1_bit  <= pix_y[2:0];
      s1_rng  <= in_range;
      s1_vld  <= valid;
      s1_bank <= active_bank;
      if (!(s1_rng && s1_vld)) begin
        pix_level <= 2'd0;
      end else if (GHOSTING) begin
        pix_level <= {cur, prev};
      end else begin
        pix_level <= {cur, cur};
      end
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// Self-checking bench for lcd_scanout: capture timing, ghosting levels,
// overrun, mid-capture reset and the read path, for GHOSTING=1 and 0.
module tb_lcd_scanout;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] read_x;
  logic [3:0] read_y;
  logic [7:0] read_column = 8'h00;
  logic       busy;
  logic       frame_done;
  logic       overrun;
  logic [6:0] pix_x = '0;
  logic [5:0] pix_y = '0;
  logic [1:0] pix_level;

  logic [7:0] read_x0;
  logic [3:0] read_y0;
  logic       busy0;
  logic       frame_done0;
  logic       overrun0;
  logic [1:0] pix_level0;

  int lcd_mode = 0;
  int n_pass = 0;
  int n_total = 0;
  int track_err = 0;

  always #5 clk = ~clk;

  lcd_scanout #(.GHOSTING(1'b1)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .read_x(read_x), .read_y(read_y), .read_column(read_column),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .pix_x(pix_x), .pix_y(pix_y), .pix_level(pix_level)
  );

  lcd_scanout #(.GHOSTING(1'b0)) dut0 (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .read_x(read_x0), .read_y(read_y0), .read_column(read_column),
    .busy(busy0), .frame_done(frame_done0), .overrun(overrun0),
    .pix_x(pix_x), .pix_y(pix_y), .pix_level(pix_level0)
  );

  // LCD controller model: registered read, data valid the next cycle.
  always @(posedge clk) begin
    case (lcd_mode)
      0:       read_column <= read_x ^ {read_y, 4'h0};
      1:       read_column <= 8'hFF;
      default: read_column <= 8'h00;
    endcase
  end

  typedef struct {
    logic [6:0] x;
    logic [5:0] y;
    logic [1:0] e1;
    logic [1:0] e0;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic rd(input string name, input logic [6:0] x,
                    input logic [5:0] y, input int e1, input int e0);
    @(negedge clk);
    pix_x = x;
    pix_y = y;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_g1"}, pix_level, e1);
    chk({name, "_g0"}, pix_level0, e0);
  endtask

  task automatic capture(input int mode, input int ov_at, input bit timing);
    int k;
    int busy_n;
    int done_k;
    int ov_n;
    int distinct;
    int lx;
    int ly;
    int b;
    bit seen [768];
    foreach (seen[i]) seen[i] = 1'b0;
    lcd_mode = mode;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k = 0; busy_n = 0; done_k = -1; ov_n = 0;
    distinct = 0; lx = -1; ly = -1;
    while (done_k < 0 && k < 2000) begin
      if (busy) begin
        busy_n++;
        lx = int'(read_x);
        ly = int'(read_y);
        if (read_x < 96 && read_y < 8 && !seen[ly * 96 + lx]) begin
          seen[ly * 96 + lx] = 1'b1;
          distinct++;
        end
      end
      if (frame_done) done_k = k;
      if (overrun) ov_n++;
      if (busy0 != busy || frame_done0 != frame_done ||
          overrun0 != overrun || read_x0 != read_x || read_y0 != read_y)
        track_err++;
      frame_start = (k == ov_at);
      @(negedge clk);
      k++;
    end
    frame_start = 1'b0;
    chk("done_cycle", done_k, 769);
    if (timing) begin
      chk("busy_cycles", busy_n, 769);
      chk("distinct_addr", distinct, 768);
      chk("last_x", lx, 95);
      chk("last_y", ly, 7);
    end
    if (ov_at >= 0) begin
      chk("overrun_pulses", ov_n, 1);
      b = 0;
      repeat (6) begin
        @(negedge clk);
        if (busy || frame_done) b++;
      end
      chk("no_restart", b, 0);
    end
  endtask

  initial begin
    int b;
    tbl[0]  = '{7'd0,   6'd0,  2'd0, 2'd0};
    tbl[1]  = '{7'd1,   6'd0,  2'd2, 2'd3};
    tbl[2]  = '{7'd3,   6'd1,  2'd2, 2'd3};
    tbl[3]  = '{7'd4,   6'd1,  2'd0, 2'd0};
    tbl[4]  = '{7'd10,  6'd10, 2'd0, 2'd0};
    tbl[5]  = '{7'd10,  6'd12, 2'd2, 2'd3};
    tbl[6]  = '{7'd95,  6'd60, 2'd0, 2'd0};
    tbl[7]  = '{7'd95,  6'd61, 2'd2, 2'd3};
    tbl[8]  = '{7'd97,  6'd4,  2'd0, 2'd0};
    tbl[9]  = '{7'd127, 6'd63, 2'd0, 2'd0};
    tbl[10] = '{7'd50,  6'd41, 2'd2, 2'd3};
    tbl[11] = '{7'd17,  6'd16, 2'd2, 2'd3};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_read_x", read_x, 0);
    chk("rst_read_y", read_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_pix_level", pix_level, 0);
    reset = 1'b0;

    rd("not_valid", 7'd1, 6'd0, 0, 0);

    // Pattern, then zeros, then pattern: current=pattern, previous=0.
    capture(0, -1, 1'b1);
    capture(2, -1, 1'b0);
    capture(0, -1, 1'b0);
    foreach (tbl[i])
      rd($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].e1, tbl[i].e0);

    // Back-to-back requests: result appears exactly two cycles later.
    @(negedge clk);
    pix_x = 7'd0; pix_y = 6'd0;
    @(negedge clk);
    @(negedge clk);
    pix_x = 7'd1;
    @(negedge clk);
    chk("lat_n1", pix_level, 0);
    pix_x = 7'd0;
    @(negedge clk);
    chk("lat_n2", pix_level, 2);
    pix_x = 7'd1;
    @(negedge clk);
    chk("lat_n3", pix_level, 0);
    @(negedge clk);
    chk("lat_n4", pix_level, 2);

    // Ghosting sequence.
    capture(1, -1, 1'b0);
    rd("ghost_ff1", 7'd10, 6'd10, 2, 3);
    capture(1, 100, 1'b0);
    rd("ghost_ff2", 7'd10, 6'd10, 3, 3);
    rd("last_byte_bit7", 7'd95, 6'd63, 3, 3);
    rd("x96_range", 7'd96, 6'd0, 0, 0);
    capture(2, -1, 1'b0);
    rd("ghost_001", 7'd10, 6'd10, 1, 0);
    capture(2, -1, 1'b0);
    rd("ghost_002", 7'd10, 6'd10, 0, 0);
    capture(1, -1, 1'b0);
    rd("ghost_ff3", 7'd10, 6'd10, 2, 3);

    // Reset in the middle of a capture.
    lcd_mode = 0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (400) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_read_x", read_x, 0);
    chk("abort_read_y", read_y, 0);
    b = 0;
    repeat (900) begin
      @(negedge clk);
      if (busy || frame_done) b++;
    end
    chk("abort_quiet", b, 0);
    rd("abort_pix_a", 7'd10, 6'd10, 0, 0);
    rd("abort_pix_b", 7'd0, 6'd0, 0, 0);

    capture(1, -1, 1'b1);
    rd("post_abort_a", 7'd10, 6'd10, 3, 3);
    rd("post_abort_b", 7'd95, 6'd63, 3, 3);

    chk("ghost0_tracks", track_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
